neuron_mac_serial: RTL
======================

// Module: neuron_mac_serial
// PURPOSE
//  Parametrised, time-multiplexed fully-connected neuron for the ECG inference layers.
//  Accepts one N_IN-element activation vector per transaction and runs one signed MAC per
//  cycle over it. Weights and bias live in a runtime-loadable register file.
//  Adds bias, applies arithmetic shift by FRAC, then ReLU or linear saturating activation.
//  Drops in where fixed-weight per-node blocks are used; output feeds the next layer via valid/ready.
// PARAMETERS
//  DW       8  width of activations, weights, bias and output (signed two's complement)
//  N_IN     10 inputs per neuron (>=1)
//  FRAC     6  fixed-point right shift applied to the accumulator before activation
//  RELU_EN  1  1: ReLU + clamp to max positive; 0: linear, signed saturation both ends
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-low reset
//  in_data    in   N_IN*DW       activation vector; element i = in_data[i*DW +: DW]
//  in_valid   in   1             in_data valid
//  in_ready   out  1             block can accept a vector (high only in IDLE)
//  w_we       in   1             weight/bias write strobe
//  w_addr     in   clog2(N_IN+1) 0..N_IN-1 = weight i, N_IN = bias; larger addresses ignored
//  w_data     in   DW            signed write data
//  out_data   out  DW            activated result (signed)
//  out_valid  out  1             out_data valid; held until out_ready
//  out_ready  in   1             downstream accepts out_data
//  out_sat    out  1             result was clamped (qualified by out_valid)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, all weights and bias=0, acc=0, idx=0.
//   out_data=0, out_valid=0, out_sat=0. in_ready=1, because it decodes state==IDLE.
//   Reset mid-transaction aborts the transaction; no partial output is produced.
//  FSM: IDLE -> MAC -> ACT -> OUT -> IDLE.
//   IDLE: in_ready=1. On in_valid at an edge: latch in_data, set acc = sign-ext(bias), idx=0 -> MAC.
//   MAC: acc += x[idx]*w[idx] (signed DWxDW product, sign-extended); idx++.
//    Exactly N_IN cycles; after the idx==N_IN-1 edge -> ACT.
//   ACT: s = acc >>> FRAC (arithmetic).
//    RELU_EN=1: s<0 -> 0 (out_sat=0); s>2^(DW-1)-1 -> 2^(DW-1)-1 (out_sat=1); else s.
//    RELU_EN=0: clamp to [-2^(DW-1), 2^(DW-1)-1]; out_sat=1 when a clamp occurs.
//    Registers out_data, out_sat and out_valid=1 -> OUT.
//   OUT: out_data/out_sat stable while out_valid=1 and out_ready=0.
//    On out_ready at an edge: out_valid=0 -> IDLE.
//  Latency: handshake at edge k -> out_valid high after edge k+N_IN+1.
//   Minimum transaction period is N_IN+3 cycles; in_valid outside IDLE is ignored (no buffering).
//  Accumulator width ACW = 2*DW + clog2(N_IN) + 1, which makes overflow impossible.
//   The bias is added at product scale (unshifted).
//  Weight port: writes take effect at the edge and are honoured only in IDLE.
//   Writes in MAC/ACT/OUT are dropped, so the weight set is constant within a transaction.
//   w_addr > N_IN is a no-op.
//  A write and an in_valid accept on the same IDLE edge: the write lands, and the
//   transaction uses the new value (the bias is taken from w_data if w_addr==N_IN).
// TESTING (DW=8, N_IN=4, FRAC=6 unless noted)
//  1 Assert reset mid-MAC -> out_valid=0, out_data=0, in_ready=1 immediately.
//    Weights read back as 0: a vector gives out_data=0.
//  2 w={64,64,64,64}, bias=0, x={1,2,3,4}: acc=640 -> out_data=10, out_sat=0.
//    out_valid rises exactly 5 edges after accept.
//  3 w={-64,-64,-64,-64}, x={1,2,3,4}: RELU_EN=1 -> out_data=0, out_sat=0.
//    RELU_EN=0 -> out_data=-10 (8'hF6).
//  4 w=127 all, x=127 all: acc=64516, s=1008 -> out_data=127, out_sat=1.
//    Same with w=-128, RELU_EN=0 -> out_data=-128, out_sat=1.
//  5 Hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no second accept.
//    A weight write in MAC is dropped: a repeat vector gives the identical result.
//  6 bias=64, w=0, x=any -> out_data=1.
//    Write w_addr=5 (out of range) -> no state change.

Source files
------------

// File: rtl/neuron_mac_serial_if.sv
// Handshake and weight-load bundle for neuron_mac_serial.
// master = upstream/downstream environment, slave = the neuron.
interface neuron_mac_serial_if #(
    parameter int DW   = 8,
    parameter int N_IN = 10
) ();
    localparam int AW = $clog2(N_IN + 1);

    logic [N_IN*DW-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;

    modport master (
        output in_data, in_valid, w_we, w_addr, w_data, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );

    modport slave (
        input  in_data, in_valid, w_we, w_addr, w_data, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface

// File: rtl/neuron_mac_serial.sv
// Time-multiplexed neuron: one signed MAC per cycle, bias, >>>FRAC, ReLU or saturating linear.
// Latency: accept at edge k -> out_valid after edge k+N_IN+1; period N_IN+3 cycles.
// Backpressure: in_ready only in IDLE, no input buffering; result held until out_ready.
module neuron_mac_serial #(
    parameter int DW      = 8,
    parameter int N_IN    = 10,
    parameter int FRAC    = 6,
    parameter int RELU_EN = 1
) (
    input logic                clk,
    input logic                reset,
    neuron_mac_serial_if.slave bus
);
    localparam int AW  = $clog2(N_IN + 1);
    localparam int ACW = 2 * DW + $clog2(N_IN) + 1;
    localparam logic signed [ACW-1:0] S_MAX = ACW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACW-1:0] S_MIN = ~S_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_OUT} state_t;

    state_t                 state;
    logic signed [DW-1:0]   w_q [N_IN];
    logic signed [DW-1:0]   x_q [N_IN];
    logic signed [DW-1:0]   bias_q;
    logic signed [ACW-1:0]  acc;
    logic [AW-1:0]          idx;
    logic [DW-1:0]          out_q;
    logic                   out_vld_q;
    logic                   out_sat_q;

    logic signed [DW-1:0]   x_cur;
    logic signed [DW-1:0]   w_cur;
    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   bias_nxt;
    logic signed [ACW-1:0]  shifted;
    logic [DW-1:0]          act_val;
    logic                   act_sat;

    always_comb begin
        x_cur = '0;
        w_cur = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == AW'(i)) begin
                x_cur = x_q[i];
                w_cur = w_q[i];
            end
        end
        prod = (2*DW)'(x_cur) * (2*DW)'(w_cur);
    end

    // A bias write on the accepting edge must already be seen by this transaction.
    assign bias_nxt = (bus.w_we && bus.w_addr == AW'(N_IN)) ? bus.w_data : bias_q;

    always_comb begin
        shifted = acc >>> FRAC;
        act_val = shifted[DW-1:0];
        act_sat = 1'b0;
        if (RELU_EN != 0 && shifted[ACW-1]) begin
            act_val = '0;
        end else if (shifted > S_MAX) begin
            act_val = S_MAX[DW-1:0];
            act_sat = 1'b1;
        end else if (shifted < S_MIN) begin
            act_val = S_MIN[DW-1:0];
            act_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bias_q    <= '0;
            acc       <= '0;
            idx       <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            out_sat_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            // Weights only change in IDLE so a transaction sees one consistent set.
            if (state == S_IDLE && bus.w_we) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (bus.w_addr == AW'(i)) w_q[i] <= bus.w_data;
                end
                if (bus.w_addr == AW'(N_IN)) bias_q <= bus.w_data;
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N_IN; i++) begin
                            x_q[i] <= bus.in_data[i*DW +: DW];
                        end
                        acc   <= ACW'(bias_nxt);
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACW'(prod);
                    idx <= idx + 1'b1;
                    if (idx == AW'(N_IN - 1)) state <= S_ACT;
                end
                S_ACT: begin
                    out_q     <= act_val;
                    out_sat_q <= act_sat;
                    out_vld_q <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_vld_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_sat   = out_sat_q;
endmodule
